// File: rtl/count_uart_pkg.sv
// Shared types and constants for the count-to-UART reporter.
package count_uart_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } uart_state_t;

  localparam logic [7:0] ASCII_ZERO = 8'h30;
  localparam logic [7:0] ASCII_A    = 8'h41;
  localparam logic [7:0] ASCII_LF   = 8'h0A;

  // start + 8 data + stop
  localparam int FRAME_BITS = 10;

  // Nibble to upper-case ASCII hex digit.
  function automatic logic [7:0] hex_ascii(input logic [3:0] v);
    if (v < 4'd10) return ASCII_ZERO + {4'h0, v};
    else           return ASCII_A + {4'h0, v} - 8'd10;
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte transmitter with valid/ready input. Accepts a new byte in the
// last cycle of a stop bit so back-to-back bytes leave no idle gap.
//
// state   | meaning
// S_IDLE  | line high, waiting for a byte
// S_START | driving the start bit (0)
// S_DATA  | shifting out 8 data bits, LSB first
// S_STOP  | driving the stop bit (1); may accept the next byte at its end
module uart_tx_byte
  import count_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       valid,
  input  logic [7:0] data,
  output logic       ready,
  output logic       idle,
  output logic       tx
);

  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] BAUD_RELOAD = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]    BITS_RELOAD = 3'(FRAME_BITS - 3);

  uart_state_t   state, state_nx;
  logic [CW-1:0] baud_cnt;
  logic [2:0]    bits_left;
  logic [7:0]    shreg;
  logic          tx_q;
  logic          baud_tc;
  logic          accept;

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (valid)                          state_nx = S_START;
      S_START: if (baud_tc)                        state_nx = S_DATA;
      S_DATA:  if (baud_tc && bits_left == 3'd0)   state_nx = S_STOP;
      S_STOP:  if (baud_tc)                        state_nx = valid ? S_START : S_IDLE;
      default:                                     state_nx = S_IDLE;
    endcase
  end

  // Handshake outputs
  always_comb begin
    baud_tc = (baud_cnt == '0);
    idle    = (state == S_IDLE);
    ready   = idle || (state == S_STOP && baud_tc);
    accept  = valid && ready;
  end

  // Baud down-counter, shift register and registered line driver
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      baud_cnt  <= '0;
      bits_left <= '0;
      shreg     <= '0;
      tx_q      <= 1'b1;
    end else if (accept) begin
      shreg    <= data;
      baud_cnt <= BAUD_RELOAD;
      tx_q     <= 1'b0;
    end else if (state != S_IDLE) begin
      if (baud_tc) begin
        baud_cnt <= BAUD_RELOAD;
        case (state)
          S_START: begin
            tx_q      <= shreg[0];
            bits_left <= BITS_RELOAD;
          end
          S_DATA: begin
            if (bits_left == 3'd0) begin
              tx_q <= 1'b1;
            end else begin
              shreg     <= shreg >> 1;
              tx_q      <= shreg[1];
              bits_left <= bits_left - 3'd1;
            end
          end
          default: tx_q <= 1'b1;
        endcase
      end else begin
        baud_cnt <= baud_cnt - CW'(1);
      end
    end
  end

  assign tx = tx_q;

endmodule

// File: rtl/count_uart_reporter.sv
// Reports every change of the counter value as an ASCII hex digit + LF
// over UART. Changes are buffered in a small FIFO; drops set a sticky flag.
module count_uart_reporter
  import count_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 4,
  parameter int WIDTH        = 4
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [WIDTH-1:0] count,
  output logic             tx,
  output logic             busy,
  output logic             overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [WIDTH-1:0] count_q;
  logic [3:0]       count_nib;
  logic [3:0]       mem [FIFO_DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr;
  logic             empty, full;
  logic             push_req, push, pop;
  logic             byte_sel;
  logic             tx_valid, tx_ready, tx_idle;
  logic [7:0]       tx_data;

  // Zero-extend narrow counters to a nibble
  always_comb begin
    count_nib            = '0;
    count_nib[WIDTH-1:0] = count;
  end

  // FIFO flags, digit/LF selection and push/pop decisions
  always_comb begin
    empty    = (wr_ptr == rd_ptr);
    full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    push_req = (count != count_q);
    // Digits are only offered when the transmitter is idle; the LF is
    // offered as soon as its digit is accepted so it follows with no gap.
    tx_valid = byte_sel || (!empty && tx_idle);
    tx_data  = byte_sel ? ASCII_LF : hex_ascii(mem[rd_ptr[AW-1:0]]);
    pop      = !byte_sel && !empty && tx_idle && tx_ready;
    push     = push_req && (!full || pop);
  end

  // Change detect, FIFO pointers, sequencing flag and status flags
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count_q  <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      byte_sel <= 1'b0;
      busy     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      count_q <= count;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (pop)                           byte_sel <= 1'b1;
      else if (byte_sel && tx_ready)     byte_sel <= 1'b0;
      busy <= !tx_idle || !empty;
      if (push_req && !push) overflow <= 1'b1;
    end
  end

  // FIFO storage; a write into a full FIFO reuses the slot being popped
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= count_nib;
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx (
    .clk    (clk),
    .resetn (resetn),
    .valid  (tx_valid),
    .data   (tx_data),
    .ready  (tx_ready),
    .idle   (tx_idle),
    .tx     (tx)
  );

endmodule

// File: tb/tb_count_uart_reporter.sv
// Scoreboard bench: stimulus pushes expected bytes, a line monitor decodes
// UART frames and compares them in order.
module tb_count_uart_reporter;

  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic [3:0] count = 4'd0;
  logic       tx, busy, overflow;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] exp_q[$];
  logic [3:0] last_val = 4'd0;
  bit         rst_seen = 1'b0;

  logic [7:0] mon_byte;
  logic       mon_start, mon_stop;
  logic [7:0] mon_exp;

  count_uart_reporter #(
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (4),
    .WIDTH       (4)
  ) dut (
    .clk      (clk),
    .resetn   (resetn),
    .count    (count),
    .tx       (tx),
    .busy     (busy),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  always @(negedge resetn) rst_seen = 1'b1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] ref_char(input logic [3:0] v);
    int iv;
    iv = int'(v);
    if (iv < 10) return 8'(48 + iv);       // '0' + v
    else         return 8'(65 + iv - 10);  // 'A' + v - 10
  endfunction

  // Drive a new count value; record expected report if it is a change that should be kept
  task automatic apply(input logic [3:0] v, input bit keep);
    @(negedge clk);
    count = v;
    if (v != last_val && keep) begin
      exp_q.push_back(ref_char(v));
      exp_q.push_back(8'h0A);
    end
    last_val = v;
  endtask

  task automatic wait_drain(input string name);
    int i;
    i = 0;
    while ((exp_q.size() != 0 || busy !== 1'b0) && i < 4000) begin
      @(negedge clk);
      i++;
    end
    check({name, "_drained"}, exp_q.size(), 0);
  endtask

  task automatic quiet(input string name, input int cycles);
    int bad;
    bad = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0 || overflow !== 1'b0) bad++;
    end
    check(name, bad, 0);
  endtask

  // Line monitor: decode frames at bit centres and compare against the scoreboard
  initial begin
    forever begin
      @(negedge clk);
      if (resetn === 1'b1 && tx === 1'b0) begin
        rst_seen = 1'b0;
        repeat (CPB / 2) @(negedge clk);
        mon_start = tx;
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          mon_byte[i] = tx;
        end
        repeat (CPB) @(negedge clk);
        mon_stop = tx;
        if (!rst_seen && resetn === 1'b1) begin
          check("frame_bits", {30'd0, mon_stop, mon_start}, 32'h2);
          if (exp_q.size() == 0) begin
            check("unexpected_frame", {24'd0, mon_byte}, 32'hFFFF_FFFF);
          end else begin
            mon_exp = exp_q.pop_front();
            check("frame_byte", {24'd0, mon_byte}, {24'd0, mon_exp});
          end
        end
      end
    end
  end

  initial begin
    logic [3:0] v;
    int         n;
    int         w;

    resetn = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_tx", tx, 1);
    check("reset_busy", busy, 0);
    check("reset_overflow", overflow, 0);
    resetn = 1'b1;

    quiet("idle_quiet", 200);

    // 0 -> 5 with latency and frame-length checks
    apply(4'd5, 1'b1);
    @(posedge clk); #1;
    check("tx_high_at_push", tx, 1);
    @(posedge clk); #1;
    check("tx_fall_at_pop", tx, 0);
    check("busy_during_report", busy, 1);
    repeat (80) @(posedge clk); #1;
    check("tx_high_after_report", tx, 1);
    check("busy_at_last_stop_end", busy, 1);
    @(posedge clk); #1;
    check("busy_fall", busy, 0);
    wait_drain("report_5");

    apply(4'hA, 1'b1);
    wait_drain("report_A");
    apply(4'hF, 1'b1);
    wait_drain("report_F");

    // Burst: 1 popped at once, 2..5 fill the FIFO, 6 is dropped
    for (int i = 1; i <= 5; i++) apply(4'(i), 1'b1);
    apply(4'd6, 1'b0);
    repeat (2) @(negedge clk);
    check("overflow_set", overflow, 1);
    wait_drain("burst");
    check("overflow_sticky", overflow, 1);

    // Wrap 15 -> 0
    apply(4'hF, 1'b1);
    wait_drain("pre_wrap");
    apply(4'h0, 1'b1);
    wait_drain("wrap_0");

    // Random short bursts (never more than 5 changes while idle)
    for (int b = 0; b < 12; b++) begin
      n = $urandom_range(1, 5);
      for (int i = 0; i < n; i++) begin
        v = 4'($urandom_range(0, 15));
        apply(v, 1'b1);
        w = $urandom_range(0, 2);
        repeat (w) @(negedge clk);
      end
      wait_drain("random_burst");
    end

    // Reset during data bit 3 of a digit
    apply(last_val ^ 4'h8, 1'b1);
    w = 0;
    while (tx !== 1'b0 && w < 10) begin
      @(negedge clk);
      w++;
    end
    check("rst_frame_started", tx, 0);
    repeat (17) @(negedge clk);
    #2;
    resetn = 1'b0;
    #1;
    check("rst_tx", tx, 1);
    check("rst_busy", busy, 0);
    check("rst_overflow", overflow, 0);
    exp_q.delete();
    count = 4'd0;
    last_val = 4'd0;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    quiet("post_reset_quiet", 200);
    check("post_reset_no_frames", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
